// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states and datapath
// mux selects, plus the control-output bundle produced by the state decoder.
package multicycle_control_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    // Encodings are visible on CTL_state, so they are pinned explicitly.
    typedef enum logic [STATE_W-1:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StRwb    = 4'd8,
        StBranch = 4'd9,
        StJump   = 4'd10,
        StAddiEx = 4'd11,
        StAddiWb = 4'd12,
        StExc    = 4'd13,
        StLoad   = 4'd14
    } state_e;

    localparam logic [2:0] PC_SRC_ALU    = 3'b000;
    localparam logic [2:0] PC_SRC_ALUOUT = 3'b001;
    localparam logic [2:0] PC_SRC_JUMP   = 3'b010;
    localparam logic [2:0] PC_SRC_SYS    = 3'b011;
    localparam logic [2:0] PC_SRC_EXC    = 3'b100;

    localparam logic [1:0] ALU_B_RT      = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [2:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       epc_write;
    } ctl_out_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/system signal bundle. The controller uses the master modport,
// the datapath (or a testbench standing in for it) uses the slave modport.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 16
);
    import multicycle_control_pkg::*;

    logic                          SYS_load;
    logic [OPCODE_W-1:0]           CTL_opcode;
    logic                          CTL_alu_ovf;
    logic                          CTL_pc_write;
    logic                          CTL_pc_write_cond;
    logic [2:0]                    CTL_pc_src;
    logic                          CTL_ir_write;
    logic                          CTL_mem_read;
    logic                          CTL_mem_write;
    logic                          CTL_reg_write;
    logic                          CTL_reg_dst;
    logic                          CTL_mem_to_reg;
    logic                          CTL_alu_src_a;
    logic [1:0]                    CTL_alu_src_b;
    logic [1:0]                    CTL_alu_op;
    logic                          CTL_epc_write;
    logic                          CTL_cause;
    logic [STATE_W-1:0]            CTL_state;
    logic [CNT_W-1:0]              CTL_retired;

    modport master (
        input  SYS_load, CTL_opcode, CTL_alu_ovf,
        output CTL_pc_write, CTL_pc_write_cond, CTL_pc_src, CTL_ir_write, CTL_mem_read,
               CTL_mem_write, CTL_reg_write, CTL_reg_dst, CTL_mem_to_reg, CTL_alu_src_a,
               CTL_alu_src_b, CTL_alu_op, CTL_epc_write, CTL_cause, CTL_state, CTL_retired
    );

    modport slave (
        output SYS_load, CTL_opcode, CTL_alu_ovf,
        input  CTL_pc_write, CTL_pc_write_cond, CTL_pc_src, CTL_ir_write, CTL_mem_read,
               CTL_mem_write, CTL_reg_write, CTL_reg_dst, CTL_mem_to_reg, CTL_alu_src_a,
               CTL_alu_src_b, CTL_alu_op, CTL_epc_write, CTL_cause, CTL_state, CTL_retired
    );

endinterface

// File: rtl/multicycle_control_ctl_decode.sv
// Moore output decode: maps the current controller state onto the datapath control vector.
// Anything not set for a state stays 0.
module multicycle_control_ctl_decode
    import multicycle_control_pkg::*;
(
    input  state_e   state,
    output ctl_out_t ctl
);

    always_comb begin
        ctl = '0;
        unique case (state)
            StFetch: begin
                ctl.mem_read  = 1'b1;
                ctl.ir_write  = 1'b1;
                ctl.alu_src_b = ALU_B_FOUR;
                ctl.alu_op    = ALU_OP_ADD;
                ctl.pc_write  = 1'b1;
                ctl.pc_src    = PC_SRC_ALU;
            end
            // Branch target precomputed into ALUOut while the opcode is decoded.
            StDecode: begin
                ctl.alu_src_b = ALU_B_IMM_SH2;
                ctl.alu_op    = ALU_OP_ADD;
            end
            StMemAdr, StAddiEx: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALU_B_IMM;
                ctl.alu_op    = ALU_OP_ADD;
            end
            StMemRd: ctl.mem_read = 1'b1;
            StMemWb: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            StMemWr: ctl.mem_write = 1'b1;
            StExec: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALU_B_RT;
                ctl.alu_op    = ALU_OP_FUNCT;
            end
            StRwb: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            StAddiWb: ctl.reg_write = 1'b1;
            StBranch: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = ALU_B_RT;
                ctl.alu_op        = ALU_OP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_src        = PC_SRC_ALUOUT;
            end
            StJump: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = PC_SRC_JUMP;
            end
            StExc: begin
                ctl.epc_write = 1'b1;
                ctl.pc_write  = 1'b1;
                ctl.pc_src    = PC_SRC_EXC;
            end
            StLoad: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = PC_SRC_SYS;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch/decode/execute, external PC
// load and exceptions, with a retired-instruction counter and a latched exception cause.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter logic [7:0]  EXC_VECTOR = 8'h80,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 SYS_clk,
    input  logic                 SYS_reset,
    multicycle_control_if.master bus
);

    state_e           state_q, state_d;
    logic             cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    ctl_out_t         ctl;

    // The vector itself is applied in the datapath; pc_src only selects it.
    logic unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        retire  = 1'b0;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: state_d = bus.SYS_load ? StLoad : StDecode;
            StDecode: begin
                unique case (bus.CTL_opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_J:         state_d = StJump;
                    OP_ADDI:      state_d = StAddiEx;
                    default: begin
                        state_d = StExc;
                        cause_d = 1'b0;
                    end
                endcase
            end
            StMemAdr: state_d = (bus.CTL_opcode == OP_LW) ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StExec, StAddiEx: begin
                if (bus.CTL_alu_ovf) begin
                    state_d = StExc;
                    cause_d = 1'b1;
                end else begin
                    state_d = (state_q == StExec) ? StRwb : StAddiWb;
                end
            end
            StMemWb, StMemWr, StRwb, StAddiWb, StBranch, StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StExc, StLoad: state_d = StFetch;
            default:       state_d = StIdle;
        endcase
    end

    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q   <= StIdle;
            cause_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    multicycle_control_ctl_decode u_ctl_decode (
        .state (state_q),
        .ctl   (ctl)
    );

    assign bus.CTL_pc_write      = ctl.pc_write;
    assign bus.CTL_pc_write_cond = ctl.pc_write_cond;
    assign bus.CTL_pc_src        = ctl.pc_src;
    assign bus.CTL_ir_write      = ctl.ir_write;
    assign bus.CTL_mem_read      = ctl.mem_read;
    assign bus.CTL_mem_write     = ctl.mem_write;
    assign bus.CTL_reg_write     = ctl.reg_write;
    assign bus.CTL_reg_dst       = ctl.reg_dst;
    assign bus.CTL_mem_to_reg    = ctl.mem_to_reg;
    assign bus.CTL_alu_src_a     = ctl.alu_src_a;
    assign bus.CTL_alu_src_b     = ctl.alu_src_b;
    assign bus.CTL_alu_op        = ctl.alu_op;
    assign bus.CTL_epc_write     = ctl.epc_write;
    assign bus.CTL_cause         = cause_q;
    assign bus.CTL_state         = state_q;
    assign bus.CTL_retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instruction streams checked cycle by
// cycle against a per-instruction state-sequence model and a per-state output table.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [CW-1:0] exp_retired;
    logic          exp_cause;
    int            seq[$];

    multicycle_control_if #(.CNT_W(CW)) bus ();

    multicycle_control #(
        .EXC_VECTOR (8'h80),
        .CNT_W      (CW)
    ) dut (
        .SYS_clk   (clk),
        .SYS_reset (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] obs_vec();
        return {bus.CTL_pc_write, bus.CTL_pc_write_cond, bus.CTL_pc_src, bus.CTL_ir_write,
                bus.CTL_mem_read, bus.CTL_mem_write, bus.CTL_reg_write, bus.CTL_reg_dst,
                bus.CTL_mem_to_reg, bus.CTL_alu_src_a, bus.CTL_alu_src_b, bus.CTL_alu_op,
                bus.CTL_epc_write};
    endfunction

    // Output table straight from the per-state control list.
    function automatic logic [16:0] exp_vec(input int s);
        logic       pcw = 0, pcwc = 0, irw = 0, mr = 0, mw = 0, rw = 0;
        logic       rd = 0, m2r = 0, sa = 0, epc = 0;
        logic [2:0] pcs = 0;
        logic [1:0] sb = 0, aop = 0;
        case (s)
            1:  begin mr = 1; irw = 1; sb = 2'b01; pcw = 1; end
            2:  sb = 2'b11;
            3:  begin sa = 1; sb = 2'b10; end
            4:  mr = 1;
            5:  begin rw = 1; m2r = 1; end
            6:  mw = 1;
            7:  begin sa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 3'b001; end
            10: begin pcw = 1; pcs = 3'b010; end
            11: begin sa = 1; sb = 2'b10; end
            12: rw = 1;
            13: begin epc = 1; pcw = 1; pcs = 3'b100; end
            14: begin pcw = 1; pcs = 3'b011; end
            default: ;
        endcase
        return {pcw, pcwc, pcs, irw, mr, mw, rw, rd, m2r, sa, sb, aop, epc};
    endfunction

    task automatic check_cycle(input int s);
        check($sformatf("state(exp %0d)", s), 32'(bus.CTL_state), 32'(s));
        check($sformatf("outputs(st %0d)", s), 32'(obs_vec()), 32'(exp_vec(s)));
        check($sformatf("retired(st %0d)", s), 32'(bus.CTL_retired), 32'(exp_retired));
        check($sformatf("cause(st %0d)", s), 32'(bus.CTL_cause), 32'(exp_cause));
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

    // Entered at a negedge while in FETCH; leaves at the negedge of the next FETCH.
    task automatic run_instr(input logic [5:0] op, input logic ovf, input logic ld);
        bit   retires = 1'b1;
        bit   faults  = 1'b0;
        logic c_val   = 1'b0;
        seq = {};
        if (ld) begin
            seq = {1, 14};
            retires = 1'b0;
        end else if (op == OP_LW)    seq = {1, 2, 3, 4, 5};
        else if (op == OP_SW)        seq = {1, 2, 3, 6};
        else if (op == OP_BEQ)       seq = {1, 2, 9};
        else if (op == OP_J)         seq = {1, 2, 10};
        else if (op == OP_RTYPE)     seq = ovf ? {1, 2, 7, 13} : {1, 2, 7, 8};
        else if (op == OP_ADDI)      seq = ovf ? {1, 2, 11, 13} : {1, 2, 11, 12};
        else begin
            seq = {1, 2, 13};
            faults = 1'b1;
        end
        if (!ld && ovf && (op == OP_RTYPE || op == OP_ADDI)) begin
            faults = 1'b1;
            c_val  = 1'b1;
        end
        if (faults) retires = 1'b0;
        bus.CTL_opcode  = op;
        bus.CTL_alu_ovf = ovf;
        bus.SYS_load    = ld;
        foreach (seq[i]) begin
            if (seq[i] == 13) exp_cause = c_val;
            check_cycle(seq[i]);
            if (i == 1) bus.SYS_load = 1'b0;
            @(negedge clk);
        end
        if (retires) exp_retired++;
    endtask

    initial begin
        logic [5:0] op;
        int         n;
        rst_n           = 1'b0;
        bus.SYS_load    = 1'b0;
        bus.CTL_opcode  = '0;
        bus.CTL_alu_ovf = 1'b0;
        exp_retired     = '0;
        exp_cause       = 1'b0;

        @(negedge clk);
        check_cycle(0);
        rst_n = 1'b1;
        check_cycle(0);
        @(negedge clk);

        // Directed cases.
        run_instr(OP_LW, 1'b0, 1'b0);
        check("lw_retired", 32'(bus.CTL_retired), 32'd1);
        run_instr(OP_RTYPE, 1'b1, 1'b0);
        run_instr(6'b111111, 1'b0, 1'b0);
        run_instr(OP_SW, 1'b0, 1'b0);
        run_instr(OP_BEQ, 1'b0, 1'b1);
        run_instr(OP_BEQ, 1'b0, 1'b1);
        run_instr(OP_J, 1'b0, 1'b0);
        run_instr(OP_ADDI, 1'b1, 1'b0);
        run_instr(OP_ADDI, 1'b0, 1'b0);
        run_instr(OP_RTYPE, 1'b0, 1'b0);

        // Walk the counter round to zero with branches.
        n = (1 << CW) - int'(exp_retired);
        repeat (n) run_instr(OP_BEQ, 1'b0, 1'b0);
        check("wrap", 32'(bus.CTL_retired), 32'd0);

        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 6))
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_RTYPE;
                3: op = OP_BEQ;
                4: op = OP_J;
                5: op = OP_ADDI;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end

        // Async reset in the middle of a load word.
        run_instr(OP_RTYPE, 1'b1, 1'b0);
        run_instr(OP_J, 1'b0, 1'b0);
        bus.CTL_opcode  = OP_LW;
        bus.CTL_alu_ovf = 1'b0;
        check_cycle(1);
        @(negedge clk);
        check_cycle(2);
        @(negedge clk);
        check_cycle(3);
        @(negedge clk);
        check_cycle(4);
        #2 rst_n = 1'b0;
        #1;
        exp_retired = '0;
        exp_cause   = 1'b0;
        check_cycle(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_cycle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main controller for the MIPS datapath. It sequences one shared ALU, IMEM/DMEM, REG and the PC/IR/EPC registers over 3–5 cycles per instruction.
- It is a Moore FSM driven by the IR opcode and the ALU overflow flag.
- It also handles the external PC load (SYS_load) and undefined-opcode/overflow exceptions.
- It sits between IR and datapath muxes, replacing the single-cycle control.

Parameters:
- EXC_VECTOR, 8'h80, PC value loaded on exception.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- SYS_clk  in  1  system clock, rising edge.
- SYS_reset  in  1  asynchronous, active-low reset.
- SYS_load  in  1  request to load PC from SYS_pc_val at next instruction boundary.
- CTL_opcode  in  6  IR[31:26].
- CTL_alu_ovf  in  1  ALU signed-overflow flag, valid in EXEC/ADDI_EX.
- CTL_pc_write  out  1  unconditional PC write.
- CTL_pc_write_cond  out  1  PC write if ALU zero.
- CTL_pc_src  out  3  000 ALU result, 001 ALUOut, 010 jump target, 011 SYS_pc_val, 100 EXC_VECTOR.
- CTL_ir_write  out  1  IR load.
- CTL_mem_read  out  1  DMEM read.
- CTL_mem_write  out  1  DMEM write.
- CTL_reg_write  out  1  REG write.
- CTL_reg_dst  out  1  0 rt, 1 rd.
- CTL_mem_to_reg  out  1  0 ALUOut, 1 MDR.
- CTL_alu_src_a  out  1  0 PC, 1 rs.
- CTL_alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- CTL_alu_op  out  2  00 add, 01 sub, 10 funct.
- CTL_epc_write  out  1  EPC load (PC−4 computed by datapath).
- CTL_cause  out  1  0 undefined opcode, 1 overflow; valid with CTL_epc_write.
- CTL_state  out  4  current state encoding, for SYS_leds debug.
- CTL_retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (SYS_reset=0, async): state=IDLE, CTL_retired=0. All control outputs are 0 in IDLE.
- First SYS_clk edge after release: IDLE→FETCH.
- Outputs are pure functions of the state (Moore). Unlisted outputs are 0.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, JUMP 10, ADDI_EX 11, ADDI_WB 12, EXC 13, LOAD 14.
- FETCH:
  - Outputs: mem_read, ir_write, alu_src_b=01, alu_op=00, pc_write, pc_src=000.
  - If SYS_load=1 on the FETCH edge: go to LOAD, discarding the fetch. Otherwise go to DECODE.
- DECODE:
  - Outputs: alu_src_b=11, alu_op=00 (branch target).
  - Next state by opcode: 100011/101011→MEMADR; 000000→EXEC; 000100→BRANCH; 000010→JUMP; 001000→ADDI_EX; any other→EXC (cause 0).
- MEMADR: alu_src_a=1, alu_src_b=10. Next: lw→MEMRD, sw→MEMWR.
- MEMRD: mem_read → MEMWB.
- MEMWB: reg_write, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: mem_write → FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: CTL_alu_ovf=1→EXC (cause 1), else RWB.
- RWB: reg_write, reg_dst=1 → FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ovf→EXC (cause 1), else ADDI_WB.
- ADDI_WB: reg_write, reg_dst=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_src=001 → FETCH.
- JUMP: pc_write, pc_src=010 → FETCH.
- EXC: epc_write, pc_write, pc_src=100, cause held from the entering transition → FETCH. No reg_write or mem_write ever occurs for a faulting instruction.
- LOAD: pc_write, pc_src=011 → FETCH. SYS_load is level-sampled; if still high on the next FETCH, LOAD repeats.
- CTL_retired:
  - Increments by 1 on transitions into FETCH from MEMWB, MEMWR, RWB, ADDI_WB, BRANCH or JUMP.
  - Does not increment from EXC, LOAD or IDLE.
  - Wraps at 2^CNT_W−1 → 0.
- Latency: lw 5 cycles; sw, R-type and addi 4; beq and j 3; exception 3 or 4; load 2.
- Reset asserted mid-instruction: immediate return to IDLE with outputs 0; partial instruction abandoned; counter cleared.
- CTL_cause is a register: written on entry to EXC, retained otherwise, reset to 0.

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - state localparams;
  - pc_src, alu_src_b and alu_op encodings.
- One sub-module, ctl_decode: purely combinational state→output-vector decode. The FSM next-state logic and the counter stay in multicycle_control.

Test Plan:
- Reset low, then release → CTL_state 0, all outputs 0; after 1 clk CTL_state=1 with mem_read=ir_write=pc_write=1.
- Opcode 100011 → states 1,2,3,4,5,1; reg_write with mem_to_reg=1 only in state 5; CTL_retired 0→1.
- Opcode 000000 with CTL_alu_ovf=1 in EXEC → 1,2,7,13,1; epc_write=1, CTL_cause=1, pc_src=100; no reg_write; CTL_retired unchanged.
- Opcode 111111 → 1,2,13 with CTL_cause=0 → FETCH.
- SYS_load=1 during FETCH → next state 14 with pc_write=1, pc_src=011; drop SYS_load → FETCH then DECODE.
- Run 65536 beq instructions (CNT_W=16) → CTL_retired wraps to 0; async reset mid-MEMRD → immediate IDLE, counter 0.
